oa_writer: RTL and testbench

- Output-activation write-back stage, directly downstream of the requant/output FIFO and of the MMA controller's OA grant port.
- Drains packed int8 OA words from a show-ahead FIFO and writes them, one output row per grant, to memory over an ICB master port.
- Reports per-row completion (write_done) and whole-layer completion (oa_calc_over) back to the controller.

---
 rtl/oa_writer.sv | 161 ++++++++++++++++
 tb/tb_oa_writer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oa_writer.sv
// Output-activation writer: drains packed int8 OA words from a show-ahead FIFO and writes one output row per grant over an ICB master port.
// Latency: first command one cycle after grant; per-row completion pulses once every write response of the row is back.
// Backpressure: honours icb_cmd_ready, caps in-flight writes at MAX_OUTSTANDING, and waits for a full row in the FIFO before requesting the bus.
module oa_writer #(
    parameter int BUS_WIDTH       = 32,
    parameter int REG_WIDTH       = 32,
    parameter int CNT_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_cfg_oa,
    input  logic [REG_WIDTH-1:0]   cfg_oa_base_addr,
    input  logic [REG_WIDTH-1:0]   cfg_oa_row_stride,
    input  logic [REG_WIDTH-1:0]   cfg_oa_words_per_row,
    input  logic [REG_WIDTH-1:0]   cfg_oa_rows,
    input  logic                   fifo_empty,
    input  logic [CNT_WIDTH-1:0]   fifo_count,
    input  logic [BUS_WIDTH-1:0]   fifo_rdata,
    output logic                   fifo_rd_en,
    output logic                   write_oa_req,
    input  logic                   write_oa_granted,
    output logic                   write_done,
    output logic                   oa_calc_over,
    output logic                   icb_cmd_valid,
    input  logic                   icb_cmd_ready,
    output logic [REG_WIDTH-1:0]   icb_cmd_addr,
    output logic                   icb_cmd_read,
    output logic [BUS_WIDTH-1:0]   icb_cmd_wdata,
    output logic [BUS_WIDTH/8-1:0] icb_cmd_wmask,
    input  logic                   icb_rsp_valid,
    output logic                   icb_rsp_ready,
    input  logic                   icb_rsp_err,
    output logic                   oa_err,
    output logic                   oa_busy
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, WRITE, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] stride_q, words_q, rows_q;
    logic [REG_WIDTH-1:0] row_idx_q, row_idx_d, word_idx_q, word_idx_d;
    logic [REG_WIDTH-1:0] row_addr_q, row_addr_d, addr_q, addr_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic                 err_q, err_d, zero_over_q, zero_over_d;
    logic                 load_cfg, cmd_hs, rsp_dec, row_last;

    assign cmd_hs   = icb_cmd_valid && icb_cmd_ready;
    // A response with nothing in flight is a protocol violation and must not underflow the counter.
    assign rsp_dec  = icb_rsp_valid && (outst_q != '0);
    assign row_last = (row_idx_q == rows_q - REG_WIDTH'(1));

    assign icb_cmd_addr  = addr_q;
    assign icb_cmd_wdata = fifo_rdata;
    assign icb_cmd_wmask = '1;
    assign icb_cmd_read  = 1'b0;
    assign icb_rsp_ready = 1'b1;
    assign oa_err        = err_q;
    assign oa_busy       = (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        state_d       = state_q;
        row_idx_d     = row_idx_q;
        word_idx_d    = word_idx_q;
        row_addr_d    = row_addr_q;
        addr_d        = addr_q;
        outst_d       = outst_q + OW'(cmd_hs) - OW'(rsp_dec);
        err_d         = err_q | (icb_rsp_valid & icb_rsp_err);
        zero_over_d   = 1'b0;
        load_cfg      = 1'b0;
        fifo_rd_en    = 1'b0;
        write_oa_req  = 1'b0;
        icb_cmd_valid = 1'b0;
        write_done    = 1'b0;
        oa_calc_over  = zero_over_q;
        case (state_q)
            IDLE, DONE: begin
                if (init_cfg_oa) begin
                    load_cfg   = 1'b1;
                    row_idx_d  = '0;
                    word_idx_d = '0;
                    row_addr_d = cfg_oa_base_addr;
                    addr_d     = cfg_oa_base_addr;
                    err_d      = 1'b0;
                    if (cfg_oa_rows == '0 || cfg_oa_words_per_row == '0) begin
                        zero_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (REG_WIDTH'(fifo_count) >= words_q) state_d = REQ;
            end
            REQ: begin
                write_oa_req = 1'b1;
                if (write_oa_granted) state_d = WRITE;
            end
            WRITE: begin
                icb_cmd_valid = !fifo_empty && (outst_q < OW'(MAX_OUTSTANDING));
                if (cmd_hs) begin
                    fifo_rd_en = 1'b1;
                    word_idx_d = word_idx_q + REG_WIDTH'(1);
                    addr_d     = addr_q + REG_WIDTH'(BYTES);
                    if (word_idx_q == words_q - REG_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_q == '0 || (outst_q == OW'(1) && rsp_dec)) begin
                    write_done = 1'b1;
                    row_idx_d  = row_idx_q + REG_WIDTH'(1);
                    word_idx_d = '0;
                    row_addr_d = row_addr_q + stride_q;
                    addr_d     = row_addr_q + stride_q;
                    if (row_last) begin
                        oa_calc_over = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            words_q     <= '0;
            rows_q      <= '0;
            row_idx_q   <= '0;
            word_idx_q  <= '0;
            row_addr_q  <= '0;
            addr_q      <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            zero_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            word_idx_q  <= word_idx_d;
            row_addr_q  <= row_addr_d;
            addr_q      <= addr_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            zero_over_q <= zero_over_d;
            if (load_cfg) begin
                stride_q <= cfg_oa_row_stride;
                words_q  <= cfg_oa_words_per_row;
                rows_q   <= cfg_oa_rows;
            end
        end
    end

endmodule

// File: tb/tb_oa_writer.sv
// Directed bench for oa_writer: FIFO, grant and ICB slave models around the DUT, hand-derived expectations.
module tb_oa_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_cfg_oa = 1'b0;
    logic [31:0] cfg_base = '0, cfg_stride = '0, cfg_words = '0, cfg_rows = '0;
    logic        fifo_empty, fifo_rd_en;
    logic [7:0]  fifo_count;
    logic [31:0] fifo_rdata;
    logic        write_oa_req, write_oa_granted, write_done, oa_calc_over;
    logic        icb_cmd_valid, icb_cmd_read, icb_rsp_ready, oa_err, oa_busy;
    logic        icb_cmd_ready = 1'b1;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_err;

    always #5 clk = ~clk;

    oa_writer dut (
        .clk(clk), .rst_n(rst_n), .init_cfg_oa(init_cfg_oa),
        .cfg_oa_base_addr(cfg_base), .cfg_oa_row_stride(cfg_stride),
        .cfg_oa_words_per_row(cfg_words), .cfg_oa_rows(cfg_rows),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count), .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en), .write_oa_req(write_oa_req),
        .write_oa_granted(write_oa_granted), .write_done(write_done),
        .oa_calc_over(oa_calc_over), .icb_cmd_valid(icb_cmd_valid),
        .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
        .icb_cmd_wmask(icb_cmd_wmask), .icb_rsp_valid(icb_rsp_valid),
        .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
        .oa_err(oa_err), .oa_busy(oa_busy)
    );

    // Show-ahead FIFO model; fifo_count can be forced to test the row-threshold gate.
    logic [31:0] mem [0:255];
    int          wr_ptr = 0, rd_ptr = 0;
    logic        cnt_ovr = 1'b0;
    logic [7:0]  cnt_val = '0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_count = cnt_ovr ? cnt_val : 8'(wr_ptr - rd_ptr);
    assign fifo_rdata = mem[rd_ptr[7:0]];
    always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 1;

    // Controller grants with a one-cycle pulse, one cycle after the request appears.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) write_oa_granted <= 1'b0;
        else        write_oa_granted <= write_oa_req && !write_oa_granted;
    end

    // ICB slave: logs commands, answers each one a cycle later unless responses are held.
    int          pend = 0, rsp_n = 0, err_at = -1, log_n = 0;
    logic        rsp_hold = 1'b0;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    always @(posedge clk or negedge rst_n) begin : icb_slave
        logic rv, re;
        if (!rst_n) begin
            pend = 0;
            icb_rsp_valid <= 1'b0;
            icb_rsp_err   <= 1'b0;
        end else begin
            rv = 1'b0;
            re = 1'b0;
            if (!rsp_hold && pend > 0) begin
                rv = 1'b1;
                re = (rsp_n == err_at);
                pend--;
                rsp_n++;
            end
            if (icb_cmd_valid && icb_cmd_ready) begin
                log_addr[log_n] = icb_cmd_addr;
                log_data[log_n] = icb_cmd_wdata;
                log_n++;
                pend++;
            end
            icb_rsp_valid <= rv;
            icb_rsp_err   <= re;
        end
    end

    int done_n = 0, calc_n = 0, both_n = 0, rsp_tot = 0, done_rsp = 0;
    always @(posedge clk) begin
        if (icb_rsp_valid) rsp_tot++;
        if (write_done) begin
            done_n++;
            done_rsp = rsp_tot;
        end
        if (oa_calc_over) calc_n++;
        if (write_done && oa_calc_over) both_n++;
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int n, input logic [31:0] seed);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 256] = seed + 32'(i);
            wr_ptr++;
        end
    endtask

    task automatic do_init(input logic [31:0] b, input logic [31:0] s,
                           input logic [31:0] w, input logic [31:0] r);
        @(negedge clk);
        cfg_base = b; cfg_stride = s; cfg_words = w; cfg_rows = r;
        init_cfg_oa = 1'b1;
        @(negedge clk);
        init_cfg_oa = 1'b0;
    endtask

    task automatic wait_calc(input int target, input string tag);
        int n = 0;
        while (calc_n < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(calc_n), 32'(target));
    endtask

    task automatic wait_log(input int target, input string tag);
        int n = 0;
        while (log_n < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(log_n), 32'(target));
    endtask

    task automatic check_cmds(input int l0, input int r0, input logic [31:0] base,
                              input logic [31:0] stride, input int words, input int rows,
                              input string tag);
        for (int r = 0; r < rows; r++) begin
            for (int w = 0; w < words; w++) begin
                int k;
                k = r * words + w;
                check({tag, "_addr"}, log_addr[l0 + k], base + 32'(r) * stride + 32'(w * 4));
                check({tag, "_data"}, log_data[l0 + k], mem[(r0 + k) % 256]);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int l0, r0, d0, c0, b0, rs0;
        #1;
        check("rst_req", write_oa_req, 0);
        check("rst_cmd_valid", icb_cmd_valid, 0);
        check("rst_wmask", icb_cmd_wmask, 4'hF);
        check("rst_rsp_ready", icb_rsp_ready, 1);
        check("rst_cmd_read", icb_cmd_read, 0);
        check("rst_busy", oa_busy, 0);
        check("rst_done", write_done, 0);
        check("rst_calc_over", oa_calc_over, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_err", oa_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two rows of four words, grant one cycle after request, immediate responses.
        @(negedge clk);
        push(8, 32'hA000_0000);
        l0 = log_n; r0 = rd_ptr; d0 = done_n; c0 = calc_n; b0 = both_n;
        do_init(32'h1000, 32'h40, 4, 2);
        wait_calc(c0 + 1, "t1_calc_wait");
        repeat (3) @(negedge clk);
        check("t1_ncmd", 32'(log_n - l0), 8);
        check_cmds(l0, r0, 32'h1000, 32'h40, 4, 2, "t1");
        check("t1_addr_last", log_addr[l0 + 7], 32'h104C);
        check("t1_done_cnt", 32'(done_n - d0), 2);
        check("t1_calc_cnt", 32'(calc_n - c0), 1);
        check("t1_calc_with_done", 32'(both_n - b0), 1);
        check("t1_busy_after", oa_busy, 0);
        check("t1_cmd_read", icb_cmd_read, 0);

        // Row-threshold gate: three of four words present must not request the bus.
        @(negedge clk);
        push(4, 32'hB000_0000);
        cnt_ovr = 1'b1; cnt_val = 8'd3;
        l0 = log_n; r0 = rd_ptr; c0 = calc_n;
        do_init(32'h2000, 32'h10, 4, 1);
        repeat (8) @(negedge clk);
        check("t2_req_low", write_oa_req, 0);
        check("t2_busy", oa_busy, 1);
        check("t2_no_cmd", 32'(log_n - l0), 0);
        cnt_val = 8'd4;
        @(negedge clk);
        check("t2_req_high", write_oa_req, 1);
        cnt_ovr = 1'b0;
        wait_calc(c0 + 1, "t2_calc_wait");
        check_cmds(l0, r0, 32'h2000, 32'h10, 4, 1, "t2");

        // Outstanding limit: six words with responses withheld.
        @(negedge clk);
        push(6, 32'hC000_0000);
        rsp_hold = 1'b1;
        l0 = log_n; r0 = rd_ptr; d0 = done_n; c0 = calc_n; rs0 = rsp_tot;
        do_init(32'h4000, 32'h100, 6, 1);
        wait_log(l0 + 4, "t3_first4");
        repeat (4) @(negedge clk);
        check("t3_cap4", 32'(log_n - l0), 4);
        check("t3_valid_low", icb_cmd_valid, 0);
        for (int i = 0; i < 2; i++) begin
            rsp_hold = 1'b0;
            @(negedge clk);
            rsp_hold = 1'b1;
            repeat (4) @(negedge clk);
            check("t3_release", 32'(log_n - l0), 32'(5 + i));
        end
        check("t3_no_done_yet", 32'(done_n - d0), 0);
        rsp_hold = 1'b0;
        wait_calc(c0 + 1, "t3_calc_wait");
        check("t3_done_after_6rsp", 32'(done_rsp - rs0), 6);
        check_cmds(l0, r0, 32'h4000, 32'h100, 6, 1, "t3");

        // Empty layer: no traffic, one oa_calc_over pulse the cycle after init.
        l0 = log_n; c0 = calc_n;
        @(negedge clk);
        cfg_base = 32'h2000; cfg_stride = 32'h4; cfg_words = 4; cfg_rows = 0;
        init_cfg_oa = 1'b1;
        check("t4_calc_not_yet", oa_calc_over, 0);
        @(negedge clk);
        init_cfg_oa = 1'b0;
        check("t4_calc_pulse", oa_calc_over, 1);
        @(negedge clk);
        check("t4_calc_low", oa_calc_over, 0);
        repeat (5) @(negedge clk);
        check("t4_no_cmd", 32'(log_n - l0), 0);
        check("t4_calc_once", 32'(calc_n - c0), 1);
        check("t4_no_req", write_oa_req, 0);

        // Error response on the second word: sticky until the next init.
        @(negedge clk);
        push(4, 32'hD000_0000);
        l0 = log_n; r0 = rd_ptr; d0 = done_n; c0 = calc_n;
        err_at = rsp_n + 1;
        do_init(32'h5000, 32'h20, 4, 1);
        wait_calc(c0 + 1, "t5_calc_wait");
        check("t5_err_set", oa_err, 1);
        check("t5_done", 32'(done_n - d0), 1);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", oa_err, 1);
        err_at = -1;
        do_init(32'h0, 32'h0, 0, 1);
        check("t5_err_cleared", oa_err, 0);

        // Asynchronous reset mid-row with two writes in flight.
        @(negedge clk);
        push(4, 32'hE000_0000);
        rsp_hold = 1'b1;
        l0 = log_n;
        do_init(32'h6000, 32'h4, 4, 1);
        wait_log(l0 + 2, "t6_two_cmds");
        icb_cmd_ready = 1'b0;
        check("t6_busy_before", oa_busy, 1);
        check("t6_valid_before", icb_cmd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_rst", icb_cmd_valid, 0);
        check("t6_busy_rst", oa_busy, 0);
        check("t6_rd_en_rst", fifo_rd_en, 0);
        check("t6_req_rst", write_oa_req, 0);
        check("t6_wmask_rst", icb_cmd_wmask, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        icb_cmd_ready = 1'b1;
        rsp_hold = 1'b0;
        @(negedge clk);
        check("t6_idle_after", oa_busy, 0);

        // Fresh run after reset, with the address wrapping past 2^32.
        push(2, 32'hF000_0000);
        l0 = log_n; r0 = rd_ptr; c0 = calc_n;
        do_init(32'hFFFF_FFF8, 32'h10, 4, 1);
        wait_calc(c0 + 1, "t7_calc_wait");
        check("t7_ncmd", 32'(log_n - l0), 4);
        check_cmds(l0, r0, 32'hFFFF_FFF8, 32'h10, 4, 1, "t7");
        check("t7_wrap_addr", log_addr[l0 + 2], 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
